// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush kill and memory-stall hold.
// Also keeps a saturating count of inserted load-use bubbles.
module idex_hazard_reg #(
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [2:0]     id_rs,
  input  logic           id_rs_v,
  input  logic [2:0]     id_rt,
  input  logic           id_rt_v,
  input  logic [2:0]     id_rd,
  input  logic           id_wr,
  input  logic           id_mem_rd,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [DW-1:0]  id_imm,
  input  logic [CW-1:0]  id_ctrl,
  input  logic           flush,
  input  logic           mem_stall,
  output logic           ex_valid,
  output logic [2:0]     ex_rs,
  output logic [2:0]     ex_rt,
  output logic           ex_rs_v,
  output logic           ex_rt_v,
  output logic [2:0]     ex_rd,
  output logic           ex_wr,
  output logic           ex_mem_rd,
  output logic [DW-1:0]  ex_rs_data,
  output logic [DW-1:0]  ex_rt_data,
  output logic [DW-1:0]  ex_imm,
  output logic [CW-1:0]  ex_ctrl,
  output logic           stall_fd,
  output logic [SCW-1:0] lu_stall_cnt
);

  typedef enum logic [1:0] {RUN, HOLD, HOLD_FL} state_t;

  typedef struct packed {
    logic          valid;
    logic [2:0]    rs;
    logic          rs_v;
    logic [2:0]    rt;
    logic          rt_v;
    logic [2:0]    rd;
    logic          wr;
    logic          mem_rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
  } idex_t;

  state_t         state_q, state_d;
  idex_t          ex_q, ex_d, id_w;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic           flush_pend, kill, lu_hz;

  assign id_w = {id_valid, id_rs, id_rs_v, id_rt, id_rt_v, id_rd, id_wr, id_mem_rd,
                 id_rs_data, id_rt_data, id_imm, id_ctrl};

  // A flush seen during a memory stall is remembered only by sitting in HOLD_FL.
  assign flush_pend = (state_q == HOLD_FL);
  assign kill       = flush | flush_pend;
  assign lu_hz      = ex_q.valid & ex_q.mem_rd & ex_q.wr & id_valid &
                      ((id_rs_v & (id_rs == ex_q.rd)) | (id_rt_v & (id_rt == ex_q.rd)));
  assign stall_fd   = mem_stall | (lu_hz & ~kill);

  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    cnt_d   = cnt_q;
    if (mem_stall) begin
      state_d = kill ? HOLD_FL : HOLD;
    end else begin
      // Leaving HOLD/HOLD_FL is evaluated exactly like a RUN cycle.
      state_d = RUN;
      if (kill) begin
        ex_d = '0;
      end else if (lu_hz) begin
        ex_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        ex_d = id_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_rs_v      = ex_q.rs_v;
  assign ex_rt_v      = ex_q.rt_v;
  assign ex_rd        = ex_q.rd;
  assign ex_wr        = ex_q.wr;
  assign ex_mem_rd    = ex_q.mem_rd;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_ctrl      = ex_q.ctrl;
  assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Bench for idex_hazard_reg: directed scenarios plus randomized traffic against a
// cycle-level reference model of the ID/EX stage (counter narrowed to 4 bits).
module tb_idex_hazard_reg;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int SCW = 4;

  typedef struct packed {
    logic          valid;
    logic [2:0]    rs;
    logic          rs_v;
    logic [2:0]    rt;
    logic          rt_v;
    logic [2:0]    rd;
    logic          wr;
    logic          mem_rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
  } fld_t;

  logic clk = 1'b0;
  logic rst, flush, mem_stall;
  fld_t id_in, ex_obs, m_ex;
  logic           m_pend;
  logic [SCW-1:0] m_cnt;

  logic           ex_valid, ex_rs_v, ex_rt_v, ex_wr, ex_mem_rd, stall_fd;
  logic [2:0]     ex_rs, ex_rt, ex_rd;
  logic [DW-1:0]  ex_rs_data, ex_rt_data, ex_imm;
  logic [CW-1:0]  ex_ctrl;
  logic [SCW-1:0] lu_stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  idex_hazard_reg #(.DW(DW), .CW(CW), .SCW(SCW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_in.valid), .id_rs(id_in.rs), .id_rs_v(id_in.rs_v),
    .id_rt(id_in.rt), .id_rt_v(id_in.rt_v), .id_rd(id_in.rd), .id_wr(id_in.wr),
    .id_mem_rd(id_in.mem_rd), .id_rs_data(id_in.rs_data), .id_rt_data(id_in.rt_data),
    .id_imm(id_in.imm), .id_ctrl(id_in.ctrl), .flush(flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_v(ex_rs_v), .ex_rt_v(ex_rt_v),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_mem_rd(ex_mem_rd), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_fd(stall_fd), .lu_stall_cnt(lu_stall_cnt)
  );

  assign ex_obs = {ex_valid, ex_rs, ex_rs_v, ex_rt, ex_rt_v, ex_rd, ex_wr, ex_mem_rd,
                   ex_rs_data, ex_rt_data, ex_imm, ex_ctrl};

  // Does the instruction in ID need the result of a load sitting in EX?
  function automatic logic needs_load(fld_t ex, fld_t id);
    return ex.valid && ex.mem_rd && ex.wr && id.valid &&
           ((id.rs_v && id.rs == ex.rd) || (id.rt_v && id.rt == ex.rd));
  endfunction

  // Reference: what the EX slot, pending-flush flag and counter become after this edge.
  task automatic model_step();
    if (rst) begin
      m_ex = '0; m_pend = 1'b0; m_cnt = '0;
    end else if (mem_stall) begin
      m_pend = m_pend | flush;
    end else if (flush || m_pend) begin
      m_ex = '0; m_pend = 1'b0;
    end else if (needs_load(m_ex, id_in)) begin
      m_ex = '0;
      if (int'(m_cnt) < (1 << SCW) - 1) m_cnt = m_cnt + 1'b1;
    end else begin
      m_ex = id_in;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic fld_t rand_fld();
    fld_t f;
    f.valid   = ($urandom_range(0, 7) != 0);
    f.rs      = 3'($urandom_range(0, 3));
    f.rs_v    = 1'($urandom);
    f.rt      = 3'($urandom_range(0, 3));
    f.rt_v    = 1'($urandom);
    f.rd      = 3'($urandom_range(0, 3));
    f.wr      = 1'($urandom);
    f.mem_rd  = 1'($urandom);
    f.rs_data = DW'($urandom);
    f.rt_data = DW'($urandom);
    f.imm     = DW'($urandom);
    f.ctrl    = CW'($urandom);
    return f;
  endfunction

  function automatic fld_t mk_load(logic [2:0] rd);
    fld_t f = '0;
    f.valid = 1'b1; f.wr = 1'b1; f.mem_rd = 1'b1; f.rd = rd; f.rs = 3'd7; f.rs_v = 1'b1;
    f.imm = DW'($urandom); f.ctrl = CW'($urandom) | CW'(1);
    return f;
  endfunction

  function automatic fld_t mk_alu(logic [2:0] rs, logic rs_v, logic [2:0] rt, logic rt_v,
                                  logic [2:0] rd);
    fld_t f = '0;
    f.valid = 1'b1; f.wr = 1'b1; f.rs = rs; f.rs_v = rs_v; f.rt = rt; f.rt_v = rt_v; f.rd = rd;
    f.rs_data = DW'($urandom); f.rt_data = DW'($urandom); f.ctrl = CW'($urandom) | CW'(2);
    return f;
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; mem_stall = 1'b0; id_in = rand_fld();
    tick(); tick();
    rst = 1'b0; id_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'($urandom); mem_stall = 1'($urandom); id_in = rand_fld();
    tick();
    id_in = rand_fld(); flush = 1'($urandom); mem_stall = 1'($urandom);
    tick();
    n_total++;
    if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %b exp 0", ex_valid);
    else n_pass++;
    n_total++;
    if (ex_wr !== 1'b0) $display("FAIL reset_ex_wr got %b exp 0", ex_wr);
    else n_pass++;
    n_total++;
    if (lu_stall_cnt !== '0) $display("FAIL reset_cnt got %0d exp 0", lu_stall_cnt);
    else n_pass++;
    #1;
    n_total++;
    if (stall_fd !== mem_stall) $display("FAIL reset_stall_fd got %b exp %b", stall_fd, mem_stall);
    else n_pass++;
    rst = 1'b0; flush = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic test_load_use();
    fld_t add;
    do_reset();
    id_in = mk_load(3'd3); tick();
    add = mk_alu(3'd3, 1'b1, 3'd5, 1'b1, 3'd4);
    id_in = add; #1;
    n_total++;
    if (stall_fd !== 1'b1) $display("FAIL lu_stall_fd got %b exp 1", stall_fd);
    else n_pass++;
    tick();
    n_total++;
    if (ex_valid !== 1'b0 || lu_stall_cnt !== SCW'(1))
      $display("FAIL lu_bubble got valid=%b cnt=%0d exp valid=0 cnt=1", ex_valid, lu_stall_cnt);
    else n_pass++;
    n_total++;
    if (stall_fd !== 1'b0) $display("FAIL lu_release got %b exp 0", stall_fd);
    else n_pass++;
    tick();
    n_total++;
    if (ex_valid !== 1'b1 || ex_rs !== 3'd3 || ex_obs !== add)
      $display("FAIL lu_add_enters got %h exp %h", ex_obs, add);
    else n_pass++;
  endtask

  task automatic test_rs_unused();
    fld_t add;
    do_reset();
    id_in = mk_load(3'd3); tick();
    add = mk_alu(3'd3, 1'b0, 3'd5, 1'b1, 3'd4);
    id_in = add; #1;
    n_total++;
    if (stall_fd !== 1'b0) $display("FAIL unused_stall_fd got %b exp 0", stall_fd);
    else n_pass++;
    tick();
    n_total++;
    if (ex_obs !== add || lu_stall_cnt !== '0)
      $display("FAIL unused_enters got %h cnt=%0d exp %h cnt=0", ex_obs, lu_stall_cnt, add);
    else n_pass++;
  endtask

  task automatic test_lu_flush();
    do_reset();
    id_in = mk_load(3'd3); tick();
    id_in = mk_alu(3'd2, 1'b1, 3'd3, 1'b1, 3'd1); flush = 1'b1; #1;
    n_total++;
    if (stall_fd !== 1'b0) $display("FAIL luflush_stall_fd got %b exp 0", stall_fd);
    else n_pass++;
    tick();
    flush = 1'b0;
    n_total++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || lu_stall_cnt !== '0)
      $display("FAIL luflush_bubble got valid=%b ctrl=%h cnt=%0d exp 0/0/0",
               ex_valid, ex_ctrl, lu_stall_cnt);
    else n_pass++;
  endtask

  task automatic test_stall_flush();
    fld_t x, y;
    do_reset();
    x = mk_alu(3'd1, 1'b1, 3'd2, 1'b1, 3'd5);
    id_in = x; tick();
    y = mk_alu(3'd6, 1'b1, 3'd7, 1'b1, 3'd2);
    id_in = y; mem_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1); #1;
      n_total++;
      if (stall_fd !== 1'b1) $display("FAIL stall_fd_c%0d got %b exp 1", c, stall_fd);
      else n_pass++;
      tick();
      n_total++;
      if (ex_obs !== x) $display("FAIL stall_hold_c%0d got %h exp %h", c, ex_obs, x);
      else n_pass++;
    end
    mem_stall = 1'b0; flush = 1'b0; #1;
    n_total++;
    if (stall_fd !== 1'b0) $display("FAIL stall_exit_fd got %b exp 0", stall_fd);
    else n_pass++;
    tick();
    n_total++;
    if (ex_valid !== 1'b0) $display("FAIL stall_exit_bubble got %b exp 0", ex_valid);
    else n_pass++;
    tick();
    n_total++;
    if (ex_obs !== y) $display("FAIL stall_resume got %h exp %h", ex_obs, y);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    fld_t z;
    do_reset();
    mem_stall = 1'b1; flush = 1'b1; tick();
    flush = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; mem_stall = 1'b0;
    z = mk_alu(3'd1, 1'b1, 3'd0, 1'b0, 3'd6);
    id_in = z; tick();
    n_total++;
    if (ex_obs !== z) $display("FAIL rst_drops_pend got %h exp %h", ex_obs, z);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < (1 << SCW) + 2; i++) begin
      id_in = mk_load(3'd1); tick();
      id_in = mk_alu(3'd1, 1'b1, 3'd0, 1'b0, 3'd2); tick();
      if (i == (1 << SCW) - 2 || i == (1 << SCW) + 1) begin
        n_total++;
        if (lu_stall_cnt !== {SCW{1'b1}})
          $display("FAIL sat_cnt_ev%0d got %0d exp %0d", i + 1, lu_stall_cnt, (1 << SCW) - 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic exp_stall;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mem_stall = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      id_in     = rand_fld();
      if ($urandom_range(0, 2) == 0) begin
        id_in.valid = 1'b1; id_in.rs_v = 1'b1; id_in.rs = m_ex.rd;
      end
      #1;
      exp_stall = mem_stall | (needs_load(m_ex, id_in) & ~(flush | m_pend));
      n_total++;
      if (stall_fd !== exp_stall)
        $display("FAIL rnd_stall_fd cyc %0d got %b exp %b", i, stall_fd, exp_stall);
      else n_pass++;
      tick();
      n_total++;
      if (ex_obs !== m_ex || lu_stall_cnt !== m_cnt)
        $display("FAIL rnd_state cyc %0d got %h cnt=%0d exp %h cnt=%0d",
                 i, ex_obs, lu_stall_cnt, m_ex, m_cnt);
      else n_pass++;
    end
    rst = 1'b0; mem_stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_stall = 1'b0; id_in = '0;
    m_ex = '0; m_pend = 1'b0; m_cnt = '0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_rs_unused();
    test_lu_flush();
    test_stall_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
